// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit and the CPU control decoder.
//   - mdCtr opcodes (MD_*) select the MDU operation.
//   - state_t is the MDU sequencer encoding.
//   - ITER is the number of iterations per operation, one result bit per cycle.
//   - ALU_* opcodes are the integer ALU function codes, kept here so the
//     decoder drives both the alu and the mdu from a single source.
package mdu_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

endpackage

// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// An operation accepted in IDLE runs 32 single-bit iterations in CALC on
// magnitudes, then FIX applies the sign correction and writes HI/LO.
//   clk, rst_n      clock, asynchronous active-low reset
//   start, mdCtr    operation request and select (MULT/MULTU/DIV/DIVU)
//   input1, input2  rs (multiplicand / dividend), rt (multiplier / divisor)
//   hiWe, loWe      MTHI / MTLO strobes, wrData is the value written
//   busy            operation in progress
//   done            one-cycle pulse when hi/lo carry a new result
//   hi, lo          HI and LO registers
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mdCtr,
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic        hiWe,
    input  logic        loWe,
    input  logic [31:0] wrData,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [1:0]  op;
    logic [31:0] opb;      // multiplicand or divisor magnitude
    logic [63:0] acc;      // {partial product, multiplier} or {remainder, dividend/quotient}
    logic        neg_p;    // negate product or quotient in FIX
    logic        neg_r;    // negate remainder in FIX
    logic        done_r;
    logic [31:0] hi_r, lo_r;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_CALC;
            ST_CALC: if (cnt == 5'(ITER - 1)) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // ---------------- operand capture ----------------
    logic        sgn_op, a_neg, b_neg;
    logic [31:0] a_abs, b_abs;

    always_comb begin
        sgn_op = ~mdCtr[0];
        a_neg  = sgn_op & input1[31];
        b_neg  = sgn_op & input2[31];
        a_abs  = a_neg ? (~input1 + 32'd1) : input1;
        b_abs  = b_neg ? (~input2 + 32'd1) : input2;
    end

    // ---------------- iteration step ----------------
    // Multiply: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift right keeping the carry.
    // Divide: restoring step on the remainder shifted left by one. The shifted
    // remainder can reach 33 bits, so compare at 33 bits; the difference
    // always fits in 32 when the subtract is taken.
    logic [32:0] mul_sum;
    logic [63:0] acc_mul, acc_div;
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        q_ok;

    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + {1'b0, opb};
        acc_mul = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
        rem_sh  = {acc[63:32], acc[31]};
        q_ok    = (rem_sh >= {1'b0, opb});
        rem_sub = rem_sh[31:0] - opb;
        acc_div = {(q_ok ? rem_sub : rem_sh[31:0]), acc[30:0], q_ok};
    end

    // ---------------- sign correction ----------------
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        prod = neg_p ? (~acc + 64'd1) : acc;
        if (op[1]) begin
            res_lo = neg_p ? (~acc[31:0]  + 32'd1) : acc[31:0];
            res_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
        end else begin
            res_lo = prod[31:0];
            res_hi = prod[63:32];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op     <= '0;
            opb    <= '0;
            acc    <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= (state == ST_FIX);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        op  <= mdCtr;
                        if (mdCtr[1]) begin
                            acc   <= {32'd0, a_abs};
                            opb   <= b_abs;
                            // Divide by zero keeps the raw all-ones quotient.
                            neg_p <= (a_neg ^ b_neg) & (|input2);
                            neg_r <= a_neg;
                        end else begin
                            acc   <= {32'd0, b_abs};
                            opb   <= a_abs;
                            neg_p <= a_neg ^ b_neg;
                            neg_r <= 1'b0;
                        end
                    end else begin
                        if (hiWe) hi_r <= wrData;
                        if (loWe) lo_r <= wrData;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + 5'd1;
                    acc <= op[1] ? acc_div : acc_mul;
                end
                ST_FIX: begin
                    hi_r <= res_hi;
                    lo_r <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected results (and idle/busy
// probes) into queues; a monitor on the falling edge pops and compares.
module tb_mdu;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int         LAT      = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  md_ctr;
    logic [31:0] in1, in2;
    logic        hi_we, lo_we;
    logic [31:0] wr_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    mdu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mdCtr(md_ctr),
        .input1(in1), .input2(in2), .hiWe(hi_we), .loWe(lo_we),
        .wrData(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        done;
    } probe_t;

    exp_t   exp_q[$];
    probe_t probe_q[$];
    logic   end_req;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- stimulus ----------------
    task automatic probe(input string nm, input logic [31:0] h, input logic [31:0] l,
                         input logic b, input logic d);
        probe_t p;
        p.name = nm; p.hi = h; p.lo = l; p.busy = b; p.done = d;
        probe_q.push_back(p);
    endtask

    task automatic drive_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.name = nm; e.hi = eh; e.lo = el;
        exp_q.push_back(e);
        start = 1'b1; md_ctr = op; in1 = a; in2 = b;
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        drive_op(nm, op, a, b, eh, el);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; md_ctr = '0; in1 = '0; in2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0; end_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        probe("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MTHI then MTLO, then both together
        hi_we = 1'b1; wr_data = 32'h12345678;
        @(posedge clk); #1;
        hi_we = 1'b0;
        probe("mthi", 32'h12345678, 32'h0, 1'b0, 1'b0);
        lo_we = 1'b1; wr_data = 32'h9ABCDEF0;
        @(posedge clk); #1;
        lo_we = 1'b0;
        probe("mtlo", 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        probe("mthilo", 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0);
        @(posedge clk); #1;

        run_op("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult_min",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero",  OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run_op("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("div_zero_n", OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("divu_100_7", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_negdiv", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);

        // Start plus MTHI while busy must both be ignored.
        drive_op("multu_2x3", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; md_ctr = OP_DIVU; in1 = 32'd9; in2 = 32'd3;
        hi_we = 1'b1; wr_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        probe("busy_ignore", 32'd1, 32'hFFFFFFFD, 1'b1, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        probe("no_queue", 32'd0, 32'd6, 1'b0, 1'b0);

        // MTHI in the same cycle as an accepted start is dropped.
        drive_op("multu_1x1", OP_MULTU, 32'd1, 32'd1, 32'd0, 32'd1);
        hi_we = 1'b1; wr_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        probe("start_mthi", 32'd0, 32'd6, 1'b1, 1'b0);
        repeat (LAT) @(posedge clk);
        #1;

        // Reset mid-DIV aborts; start accepted on the first edge afterwards.
        start = 1'b1; md_ctr = OP_DIV; in1 = 32'd100; in2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        probe("abort_reset", 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("multu_4x4", OP_MULTU, 32'd4, 32'd4, 32'd0, 32'd16);

        probe("idle_end", 32'd0, 32'd16, 1'b0, 1'b0);
        @(posedge clk); #1;
        end_req = 1'b1;
    end

    // ---------------- monitor ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        int     cyc;
        int     busy_run;
        logic   prev_done;
        probe_t p;
        exp_t   e;
        cyc = 0; busy_run = 0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n)    busy_run = 0;
            else if (busy) busy_run++;

            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                chk({p.name, "_hi"},   hi,          p.hi);
                chk({p.name, "_lo"},   lo,          p.lo);
                chk({p.name, "_busy"}, 32'(busy),   32'(p.busy));
                chk({p.name, "_done"}, 32'(done),   32'(p.done));
            end

            if (done) begin
                chk("done_single", 32'(prev_done), 32'd0);
                chk("done_busy",   32'(busy),      32'd0);
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_hi"},  hi,             e.hi);
                    chk({e.name, "_lo"},  lo,             e.lo);
                    chk({e.name, "_lat"}, 32'(busy_run),  32'(LAT));
                end
                busy_run = 0;
            end
            prev_done = done;

            if (end_req || cyc > 5000) begin
                if (!end_req) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL timeout: got %0d cycles expected end of stimulus", cyc);
                end
                chk("pending_results", 32'(exp_q.size()), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
                $finish;
            end
        end
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameters: none; the datapath SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  operation request, sampled only in IDLE.
REQ-005 mdCtr  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 input1  input  32  multiplicand or dividend (rs).
REQ-007 input2  input  32  multiplier or divisor (rt).
REQ-008 hiWe  input  1  MTHI write strobe.
REQ-009 loWe  input  1  MTLO write strobe.
REQ-010 wrData  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and FIX; reset state is IDLE.
REQ-016 IDLE: start=1 at edge E0 SHALL latch mdCtr, |input1| and |input2| (absolute values for signed ops, raw values for unsigned ops) and the result signs, then enter CALC.
REQ-017 CALC SHALL run exactly 32 iterations: one shift-add multiply step or one restoring-divide step per cycle, with a 5-bit counter; after the 32nd iteration it SHALL enter FIX.
REQ-018 FIX SHALL apply the sign correction, write hi/lo, and return to IDLE; hi/lo and done=1 SHALL be visible after edge E0+33, and busy SHALL be 0 in that cycle.
REQ-019 busy SHALL be 1 from after E0 through the cycle before done.
REQ-020 Multiply: {hi,lo} SHALL equal the full 64-bit product, two's-complement for MULT and unsigned for MULTU.
REQ-021 Divide: lo SHALL hold the quotient truncated toward zero and hi the remainder; for DIV the remainder takes the sign of the dividend.
REQ-022 Divide by zero: hi SHALL equal input1, lo SHALL equal 32'hFFFFFFFF, and the latency SHALL be the normal 33 cycles.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL yield lo=32'h80000000, hi=0.
REQ-024 start while busy SHALL be ignored; no queuing.
REQ-025 hiWe/loWe in IDLE without start SHALL load hi/lo from wrData at the next edge; both strobes together SHALL load both registers.
REQ-026 hiWe/loWe while busy, or in the same cycle as an accepted start, SHALL be ignored.
REQ-027 hi and lo SHALL hold their value at all times except at FIX or a legal MTHI/MTLO write.
REQ-028 done SHALL never be asserted for two consecutive cycles.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the counter and internal registers.
REQ-030 Reset during CALC or FIX SHALL abort the operation without any hi/lo update or done pulse.
REQ-031 After rst_n deasserts, start SHALL be accepted on the first rising edge.

Structure
REQ-032 Package mdu_pkg SHALL hold the mdCtr opcode constants (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the state encoding, and ITER=32.
REQ-033 The shared ALU opcode constants SHALL also move into this package so the CPU control decoder drives both alu and mdu from one source.
REQ-034 The block SHALL be a single module with no sub-module: one 64-bit shift register holding the accumulator or remainder plus a 32-bit adder/subtractor.

Verification
REQ-035 MULTU FFFFFFFF x FFFFFFFF -> after 33 cycles hi=FFFFFFFE, lo=00000001, and done is high for exactly one cycle.
REQ-036 MULT FFFFFFFD (-3) x 00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; MULT 80000000 x 80000000 -> hi=40000000, lo=0.
REQ-037 DIV FFFFFFF9 (-7) / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 00000007 / 0 -> hi=00000007, lo=FFFFFFFF.
REQ-038 MULTU 2x3 started, then start with DIVU 9/3 plus hiWe=1 issued at cycle 10 -> final hi=0, lo=6; the second request and the write are ignored.
REQ-039 rst_n pulsed low at cycle 15 of a DIV -> hi=lo=0, busy=0, no done pulse; a new MULTU 4x4 then gives lo=16 at 33 cycles.
REQ-040 In IDLE, hiWe with wrData=12345678, then loWe with wrData=9ABCDEF0 -> hi=12345678, lo=9ABCDEF0, busy stays 0, and no done pulse.
